fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage that sits directly upstream of `instruction_memory`. It holds the program counter and drives `Inst_Address`, then captures the combinationally returned `Instruction`. Each fetched word is buffered with its PC in a small in-order queue and presented to decode through a valid/ready handshake. Branch/jump redirects from execute flush the queue and reload the PC.

## Interface
- `PC_WIDTH`, 64, PC and address width
- `RESET_PC`, 64'h0, PC value loaded at reset
- `QUEUE_DEPTH`, 2, fetch-queue entries (power of two, ≥2)
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset; single clock domain
- `Inst_Address`  out  PC_WIDTH  fetch address to instruction memory; always equals the PC register
- `Instruction`  in  32  word returned combinationally for `Inst_Address`, sampled same cycle
- `redirect_valid`  in  1  redirect request from execute
- `redirect_pc`  in  PC_WIDTH  redirect target
- `id_ready`  in  1  decode accepts the head entry this cycle
- `id_valid`  out  1  head entry valid
- `id_pc`  out  PC_WIDTH  PC of head entry
- `id_instruction`  out  32  instruction of head entry
- `id_fault`  out  1  misaligned-redirect fault (only with FETCH_MISALIGN_CHECK_EN)

## Operation
- Reset values: PC=RESET_PC, queue empty, `id_valid`=0, `id_pc`=0, `id_instruction`=32'h00000013 (NOP), `id_fault`=0.
- Outputs are driven from the queue head. When the queue is empty: `id_pc`=0 and `id_instruction`=NOP.
- Pop: occurs when `id_valid && id_ready`.
- Fetch: occurs each cycle with no redirect and (count<QUEUE_DEPTH or pop this cycle).
  - Push {PC, Instruction}.
  - PC <= PC+4, modulo 2^PC_WIDTH (wraps from all-ones−3 to 0).
- Full with no pop: no push; PC holds.
- Full with pop: push and pop both occur; count unchanged.
- Redirect has priority over everything:
  - Queue flushed to empty and PC <= redirect_pc.
  - No push that cycle.
  - A handshake in the same cycle completes; the decode side consumes the old head.
- Queue pointers wrap modulo QUEUE_DEPTH. Ordering is strictly FIFO.
- `reset_n` deassertion mid-operation: all state returns to reset values asynchronously; fetch resumes at RESET_PC on the first clock after release.
- FSM states:
  - RUN: normal fetch.
  - FAULT: no fetch, queue empty. Exists only with the macro.
  - Transitions:
    - RUN→FAULT on a misaligned redirect.
    - FAULT→RUN on an aligned redirect.

## Timing
- Word at address A appears on `id_*` in the cycle after `Inst_Address`=A. Fetch-to-decode latency is 1 cycle.
- Redirect asserted in cycle N:
  - `Inst_Address`=target in N+1.
  - `id_valid`=0 in N+1.
  - First target word valid in N+2.
- Sustained throughput is 1 instruction/cycle while `id_ready`=1.
- `Instruction` must settle within the same cycle as `Inst_Address`. There is no registered memory read.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 flushes the queue and enters FAULT.
  - `id_fault` goes 1 from the next cycle; `id_valid` stays 0.
  - `Inst_Address` holds the faulting target.
- `FETCH_MISALIGN_CHECK_EN` undefined:
  - `redirect_pc[1:0]` is forced to 0 on load.
  - There is no FAULT state and no `id_fault` port.

## Structure
- Package `fetch_pkg`: PC_WIDTH, RESET_PC, NOP constant 32'h00000013, PC increment constant 4, fetch-state enum (RUN, FAULT).
- Sub-module `fetch_queue`: synchronous FIFO with push/pop/flush and count.
  - Parameterised by depth and entry width (PC_WIDTH+32).
  - Async active-low reset.
- The top level holds the PC, the FSM and the fetch-enable logic.

## Test plan
- Reset release with `id_ready`=1:
  - Cycle 1: `id_pc`=0, `id_instruction`=32'h00000513.
  - Cycle 2: `id_pc`=4, `id_instruction`=32'h00000093.
  - One instruction per cycle thereafter.
- Hold `id_ready`=0 for 5 cycles after reset:
  - Queue holds PC 0 and PC 4.
  - `Inst_Address` sticks at 8.
  - On release, outputs are 0, 4, 8 in consecutive cycles with no gaps or duplicates.
- Redirect to 0x34 while full with `id_ready`=1:
  - Old head consumed; queue flushed.
  - Next cycle `id_valid`=0.
  - Following cycle `id_pc`=0x34, `id_instruction`=32'hfc411ee3.
- PC=64'hFFFF_FFFF_FFFF_FFFC fetched: next `Inst_Address`=0 (wrap).
- Assert `reset_n`=0 mid-stream with queue non-empty:
  - `id_valid`=0 and `Inst_Address`=RESET_PC immediately, without a clock edge.
- With macro, redirect to 0x36:
  - `id_fault`=1 and `id_valid`=0, held.
  - Aligned redirect to 0x40 clears `id_fault`; first word at 0x40 is valid 2 cycles later.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction-fetch stage.
//   FETCH_PC_WIDTH    default PC / fetch-address width
//   FETCH_RESET_PC    default PC loaded while reset_n is low
//   FETCH_QUEUE_DEPTH default fetch-queue depth
//   NOP_INSTR         word shown to decode when the queue is empty
//   PC_INCREMENT      sequential fetch stride in bytes
//   fetch_state_t     fetch controller states
package fetch_pkg;

    localparam int          FETCH_PC_WIDTH    = 64;
    localparam logic [63:0] FETCH_RESET_PC    = 64'h0;
    localparam int          FETCH_QUEUE_DEPTH = 2;
    localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
    localparam int          PC_INCREMENT      = 4;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small synchronous in-order FIFO holding fetched {pc, instruction}
// entries between the fetch stage and decode.
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (empties the queue)
//   push     write wdata at the tail (accepted when not full, or full with pop)
//   pop      remove the head entry (ignored when empty)
//   flush    empty the queue; dominates push and pop
//   wdata    entry to write
//   rdata    head entry (contents undefined while empty)
//   empty    queue holds no entries
//   count    number of entries held
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full queue can still accept a write when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: it is only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage in front of instruction_memory.
// Holds the PC, drives Inst_Address, captures the combinationally returned
// Instruction together with its PC into fetch_queue and hands the head entry
// to decode through a valid/ready handshake. A redirect from execute flushes
// the queue and reloads the PC.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined   : a redirect target with bits [1:0] != 0 parks the stage in FAULT
//               and raises id_fault; an aligned redirect resumes fetch.
//   undefined : redirect targets are forced word-aligned; no id_fault port.
//
// Ports:
//   clk             rising-edge clock
//   reset_n         asynchronous active-low reset
//   Inst_Address    fetch address to instruction memory (the PC register)
//   Instruction     word returned combinationally for Inst_Address
//   redirect_valid  redirect request from execute
//   redirect_pc     redirect target
//   id_ready        decode accepts the head entry this cycle
//   id_valid        head entry valid
//   id_pc           PC of head entry (0 when empty)
//   id_instruction  instruction of head entry (NOP when empty)
//   id_fault        misaligned-redirect fault (FETCH_MISALIGN_CHECK_EN only)
//
// State | meaning
// ------+-------------------------------------------------------------
// RUN   | normal sequential fetch into the queue
// FAULT | misaligned redirect seen; no fetch, queue empty, id_fault=1
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH    = FETCH_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(FETCH_RESET_PC),
    parameter int                  QUEUE_DEPTH = FETCH_QUEUE_DEPTH
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic [PC_WIDTH-1:0] Inst_Address,
    input  logic [31:0]         Instruction,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                id_ready,
    output logic                id_valid,
    output logic [PC_WIDTH-1:0] id_pc,
    output logic [31:0]         id_instruction
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                id_fault
`endif
);

    localparam int CNT_W   = $clog2(QUEUE_DEPTH) + 1;
    localparam int ENTRY_W = PC_WIDTH + 32;

    fetch_state_t        state;
    fetch_state_t        next_state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] next_pc;
    logic [PC_WIDTH-1:0] redirect_target;
    logic                fetch_en;
    logic                pop;
    logic                q_empty;
    logic [CNT_W-1:0]    q_count;
    logic [ENTRY_W-1:0]  q_head;

    assign Inst_Address = pc;
    assign id_valid     = !q_empty;
    assign pop          = id_valid && id_ready;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned;
    assign misaligned      = (redirect_pc[1:0] != 2'b00);
    // The faulting target is kept on Inst_Address for visibility.
    assign redirect_target = redirect_pc;
    assign id_fault        = (state == FAULT);
`else
    assign redirect_target = redirect_pc & ~(PC_WIDTH'(3));
`endif

    always_comb begin
        next_state = state;
        next_pc    = pc;
        fetch_en   = 1'b0;
        if (redirect_valid) begin
            next_pc = redirect_target;
`ifdef FETCH_MISALIGN_CHECK_EN
            next_state = misaligned ? FAULT : RUN;
`endif
        end else if ((state == RUN) &&
                     ((q_count < CNT_W'(QUEUE_DEPTH)) || pop)) begin
            fetch_en = 1'b1;
            next_pc  = pc + PC_WIDTH'(PC_INCREMENT);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= next_state;
            pc    <= next_pc;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fetch_en),
        .pop     (pop),
        .flush   (redirect_valid),
        .wdata   ({pc, Instruction}),
        .rdata   (q_head),
        .empty   (q_empty),
        .count   (q_count)
    );

    assign id_pc          = q_empty ? '0 : q_head[ENTRY_W-1:32];
    assign id_instruction = q_empty ? NOP_INSTR : q_head[31:0];

endmodule
